// File: rtl/arm7tdmi_pkg.sv
// Shared types and constants for the ARM7TDMI EmbeddedICE access path.
package arm7tdmi_pkg;

    localparam int unsigned ICE_ADDR_W = 5;
    localparam int unsigned ICE_DATA_W = 32;

    typedef enum logic [0:0] {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // Registers owned by the core; the host may read but never write them.
    localparam logic [ICE_ADDR_W-1:0] ICE_ADDR_STATUS = 5'h01;
    localparam logic [ICE_ADDR_W-1:0] ICE_ADDR_DATA   = 5'h03;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_HOST = 2'b01;
    localparam logic [1:0] GNT_CORE = 2'b10;

    typedef struct packed {
        logic                  we;
        logic [ICE_ADDR_W-1:0] addr;
        logic [ICE_DATA_W-1:0] wdata;
    } ice_req_t;

    function automatic logic ice_host_protected(input logic [ICE_ADDR_W-1:0] addr);
        return (addr == ICE_ADDR_STATUS) || (addr == ICE_ADDR_DATA);
    endfunction

endpackage

// File: rtl/arm7tdmi_ice_rr_pick.sv
// Stateless 2-way selector: starvation override, core urgency, then round-robin.
module arm7tdmi_ice_rr_pick
    import arm7tdmi_pkg::*;
(
    input  logic       host_req_i,
    input  logic       core_req_i,
    input  logic       host_starved_i,
    input  logic       core_urgent_i,
    input  logic       ptr_core_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = GNT_NONE;
        if (host_req_i && host_starved_i) begin
            gnt_o = GNT_HOST;
        end else if (core_req_i && core_urgent_i) begin
            gnt_o = GNT_CORE;
        end else if (host_req_i && core_req_i) begin
            gnt_o = ptr_core_i ? GNT_CORE : GNT_HOST;
        end else if (host_req_i) begin
            gnt_o = GNT_HOST;
        end else if (core_req_i) begin
            gnt_o = GNT_CORE;
        end
    end

endmodule

// File: rtl/arm7tdmi_ice_access_arb.sv
// Host/core arbiter for the EmbeddedICE register-file port, with host lock and write protection.
// Optional grant counters are built when ICE_ARB_PERF_EN is defined.
module arm7tdmi_ice_access_arb
    import arm7tdmi_pkg::*;
#(
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned LOCK_MAX     = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic              host_we,
    input  logic              host_lock,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_rsp_valid,
    output logic              host_rsp_err,
    input  logic              core_valid,
    output logic              core_ready,
    input  logic              core_we,
    input  logic              core_urgent,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              regf_en,
    output logic              regf_we,
    output logic [ADDR_W-1:0] regf_addr,
    output logic [DATA_W-1:0] regf_wdata,
    input  logic [DATA_W-1:0] regf_rdata,
    output logic              lock_timeout,
    output logic [15:0]       perf_host_grants,
    output logic [15:0]       perf_core_grants
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [7:0] LOCK_LAST  = 8'(LOCK_MAX - 1);

    arb_state_t state_q, state_d;
    logic       ptr_core_q, ptr_core_d;
    logic [3:0] starve_q, starve_d;
    logic [7:0] lock_q, lock_d;
    logic       rsp_host_q, rsp_host_d;
    logic       rsp_core_q, rsp_core_d;
    logic       rsp_wr_q, rsp_wr_d;
    logic       rsp_err_q, rsp_err_d;

    logic       locked, host_gnt, core_gnt, host_prot_wr, lock_expire;
    logic [1:0] gnt;
    ice_req_t   host_req, core_req, sel_req;

    assign locked = (state_q == ARB_LOCKED);

    // Reset gating on the request lines keeps every ready low while rst is high.
    arm7tdmi_ice_rr_pick u_pick (
        .host_req_i     (host_valid & ~rst),
        .core_req_i     (core_valid & ~rst & ~locked),
        .host_starved_i (starve_q == STARVE_MAX),
        .core_urgent_i  (core_urgent),
        .ptr_core_i     (ptr_core_q),
        .gnt_o          (gnt)
    );

    assign host_gnt   = gnt[0];
    assign core_gnt   = gnt[1];
    assign host_ready = host_gnt;
    assign core_ready = core_gnt;

    assign host_req     = '{we: host_we, addr: host_addr, wdata: host_wdata};
    assign core_req     = '{we: core_we, addr: core_addr, wdata: core_wdata};
    assign host_prot_wr = host_we & ice_host_protected(host_addr);

    always_comb begin
        sel_req = '0;
        if (host_gnt) begin
            sel_req = host_req;
        end else if (core_gnt) begin
            sel_req = core_req;
        end
    end

    // A protected host write still occupies the port, but as a harmless read strobe.
    assign regf_en    = host_gnt | core_gnt;
    assign regf_we    = sel_req.we & ~(host_gnt & host_prot_wr);
    assign regf_addr  = sel_req.addr;
    assign regf_wdata = sel_req.wdata;

    assign lock_expire  = locked & ~host_valid & ~rst & (lock_q == LOCK_LAST);
    assign lock_timeout = lock_expire;

    always_comb begin
        state_d    = state_q;
        lock_d     = lock_q;
        ptr_core_d = ptr_core_q;
        starve_d   = starve_q;

        if (host_gnt) begin
            lock_d  = '0;
            state_d = host_lock ? ARB_LOCKED : ARB_OPEN;
        end else if (locked && !host_valid) begin
            if (lock_expire) begin
                lock_d  = '0;
                state_d = ARB_OPEN;
            end else begin
                lock_d = lock_q + 8'd1;
            end
        end

        if (host_gnt) begin
            ptr_core_d = 1'b1;
        end else if (core_gnt) begin
            ptr_core_d = 1'b0;
        end

        if (!host_valid || host_gnt) begin
            starve_d = '0;
        end else if (starve_q != STARVE_MAX) begin
            starve_d = starve_q + 4'd1;
        end

        rsp_host_d = host_gnt;
        rsp_core_d = core_gnt;
        rsp_wr_d   = sel_req.we;
        rsp_err_d  = host_gnt & host_prot_wr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB_OPEN;
            ptr_core_q <= 1'b0;
            starve_q   <= '0;
            lock_q     <= '0;
            rsp_host_q <= 1'b0;
            rsp_core_q <= 1'b0;
            rsp_wr_q   <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_core_q <= ptr_core_d;
            starve_q   <= starve_d;
            lock_q     <= lock_d;
            rsp_host_q <= rsp_host_d;
            rsp_core_q <= rsp_core_d;
            rsp_wr_q   <= rsp_wr_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign host_rsp_valid = rsp_host_q & ~rst;
    assign core_rsp_valid = rsp_core_q & ~rst;
    assign host_rsp_err   = rsp_err_q & ~rst;
    assign rsp_rdata      = (!rst && (rsp_host_q || rsp_core_q) && !rsp_wr_q) ? regf_rdata : '0;

`ifdef ICE_ARB_PERF_EN
    logic [15:0] perf_host_q, perf_core_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_host_q <= '0;
            perf_core_q <= '0;
        end else begin
            if (host_gnt && perf_host_q != 16'hFFFF) begin
                perf_host_q <= perf_host_q + 16'd1;
            end
            if (core_gnt && perf_core_q != 16'hFFFF) begin
                perf_core_q <= perf_core_q + 16'd1;
            end
        end
    end

    assign perf_host_grants = rst ? 16'h0 : perf_host_q;
    assign perf_core_grants = rst ? 16'h0 : perf_core_q;
`else
    assign perf_host_grants = 16'h0;
    assign perf_core_grants = 16'h0;
`endif

endmodule
